uart_line_rx: RTL and testbench

Line-assembly stage directly downstream of the memory-mapped UART slave. It acts as the bus master on the UART's `stb/we/adr/dat/ack` port and polls the RX data register. Valid bytes are collected into an internal line buffer until a terminator or overflow. A completed line is handed to the CPU side through a ready/ack handshake and a random-access read port.

---
 rtl/uart_line_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_line_rx.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_rx.sv
// Polls the UART RX data register over a stb/we/adr/dat/ack bus and assembles lines for the CPU.
// Optional feature: define UART_LINE_ECHO_EN to write every received byte back to the UART TX register.
module uart_line_rx #(
    parameter int DEPTH         = 64,
    parameter int POLL_INTERVAL = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    output logic        line_ready,
    output logic [7:0]  line_len,
    output logic        line_trunc,
    input  logic        line_ack,
    input  logic [7:0]  rd_addr,
    output logic [7:0]  rd_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [7:0]    DEPTH_B   = 8'(DEPTH);
    localparam logic [CW-1:0] POLL_LAST = CW'(POLL_INTERVAL - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
`ifdef UART_LINE_ECHO_EN
        ECHO,
`endif
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    len_q, len_d;
    logic          trunc_q, trunc_d;
    logic [7:0]    rd_data_q;
    logic          buf_we;
    logic          line_done;
    logic [7:0]    rx_byte;
    logic          unused_bits;

    // Sized to a power of two so every index slice is exact; aliased reads are stale data.
    logic [7:0] buf_mem [0:(1 << AW) - 1];

`ifdef UART_LINE_ECHO_EN
    logic [7:0] echo_byte_q, echo_byte_d;
    logic       echo_hold_q, echo_hold_d;
`endif

    assign rx_byte     = m_dat_i[7:0];
    assign unused_bits = ^{m_dat_i[31:9], rd_addr, len_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        trunc_d   = trunc_q;
        buf_we    = 1'b0;
        line_done = 1'b0;
`ifdef UART_LINE_ECHO_EN
        echo_byte_d = echo_byte_q;
        echo_hold_d = echo_hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (cnt_q == POLL_LAST) begin
                    cnt_d   = '0;
                    state_d = RD_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RD_REQ: begin
                if (m_ack_i) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (!m_dat_i[8]) begin
                    state_d = IDLE;
                end else begin
                    if (rx_byte == 8'h0D || rx_byte == 8'h0A) begin
                        // An empty-line terminator is swallowed so CRLF yields one line.
                        if (len_q != 8'd0) begin
                            line_done = 1'b1;
                            trunc_d   = 1'b0;
                        end
                    end else if (rx_byte == 8'h08) begin
                        if (len_q != 8'd0) begin
                            len_d = len_q - 8'd1;
                        end
                    end else begin
                        buf_we = 1'b1;
                        len_d  = len_q + 8'd1;
                        if (len_q + 8'd1 == DEPTH_B) begin
                            line_done = 1'b1;
                            trunc_d   = 1'b1;
                        end
                    end
`ifdef UART_LINE_ECHO_EN
                    echo_byte_d = rx_byte;
                    echo_hold_d = line_done;
                    state_d     = ECHO;
`else
                    state_d = line_done ? HOLD : IDLE;
`endif
                end
            end
`ifdef UART_LINE_ECHO_EN
            ECHO: begin
                if (m_ack_i) begin
                    state_d = echo_hold_q ? HOLD : IDLE;
                end
            end
`endif
            HOLD: begin
                if (line_ack) begin
                    len_d   = 8'd0;
                    trunc_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= 8'd0;
            trunc_q <= 1'b0;
`ifdef UART_LINE_ECHO_EN
            echo_byte_q <= 8'd0;
            echo_hold_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
`ifdef UART_LINE_ECHO_EN
            echo_byte_q <= echo_byte_d;
            echo_hold_q <= echo_hold_d;
`endif
        end
    end

    always_ff @(posedge sys_clk) begin
        if (buf_we) begin
            buf_mem[len_q[AW-1:0]] <= rx_byte;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_data_q <= 8'd0;
        end else begin
            rd_data_q <= buf_mem[rd_addr[AW-1:0]];
        end
    end

    // Bus outputs decode straight from the state so reset drops the strobe without waiting for a clock.
`ifdef UART_LINE_ECHO_EN
    assign m_stb_o = (state_q == RD_REQ) || (state_q == ECHO);
    assign m_we_o  = (state_q == ECHO);
    assign m_dat_o = (state_q == ECHO) ? {24'h0, echo_byte_q} : 32'h0;
`else
    assign m_stb_o = (state_q == RD_REQ);
    assign m_we_o  = 1'b0;
    assign m_dat_o = 32'h0;
`endif
    assign m_adr_o    = 32'h0;
    assign line_ready = (state_q == HOLD);
    assign line_len   = len_q;
    assign line_trunc = trunc_q;
    assign rd_data    = rd_data_q;
endmodule

// File: tb/tb_uart_line_rx.sv
// Bench for uart_line_rx: UART responder, byte-level line model, directed scenarios and a random phase.
module tb_uart_line_rx;
    localparam int DEPTH = 4;
    localparam int P     = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_stb_o, m_we_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic [31:0] m_dat_i = 32'h0;
    logic        m_ack_i = 1'b0;
    logic        line_ready, line_trunc;
    logic [7:0]  line_len;
    logic        line_ack = 1'b0;
    logic [7:0]  rd_addr = 8'h0;
    logic [7:0]  rd_data;

    uart_line_rx #(.DEPTH(DEPTH), .POLL_INTERVAL(P)) dut (
        .sys_clk(clk), .sys_rst(rst),
        .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
        .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
        .line_ready(line_ready), .line_len(line_len), .line_trunc(line_trunc),
        .line_ack(line_ack), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lines_done = 0;

    // UART side
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_log[$];
    logic [7:0]  echo_exp[$];
    int          rd_stall = 0, tx_stall = 0, stall_max = 3, tx_force = -1;
    bit          data_next = 0;
    logic [31:0] data_word = 32'h0;

    // line model
    logic [7:0]  mbuf[DEPTH];
    bit          mknown[DEPTH];
    int          m_len = 0;
    bit          m_ready = 0, m_trunc = 0, m_pend_hold = 0;

    // effects of the previous cycle's stimulus
    bit          p_byte_v = 0, p_echo_ack = 0, p_line_ack = 0, p_rd_v = 0;
    logic [7:0]  p_byte = 8'h0;
    int          p_rd_idx = 0;
    bit          prev_rd_wait = 0, prev_rd_acc = 0;

    // CPU side
    bit          cpu_auto = 0, dir_ack = 0;
    int          dir_addr = 0, hold_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int next_rd_stall();
        return $urandom_range(0, stall_max);
    endfunction

    function automatic int next_tx_stall();
        return (tx_force >= 0) ? tx_force : $urandom_range(0, stall_max);
    endfunction

    task automatic model_reset();
        m_len = 0; m_ready = 0; m_trunc = 0; m_pend_hold = 0;
        p_byte_v = 0; p_echo_ack = 0; p_line_ack = 0; p_rd_v = 0;
        prev_rd_wait = 0; prev_rd_acc = 0; data_next = 0;
        echo_exp.delete();
        rd_stall = next_rd_stall();
        tx_stall = next_tx_stall();
        m_ack_i = 1'b0; m_dat_i = 32'h0; line_ack = 1'b0;
    endtask

    task automatic apply_byte(input logic [7:0] b);
        bit done = 0;
`ifdef UART_LINE_ECHO_EN
        echo_exp.push_back(b);
`endif
        if (b == 8'h0D || b == 8'h0A) begin
            if (m_len > 0) begin done = 1; m_trunc = 0; end
        end else if (b == 8'h08) begin
            if (m_len > 0) m_len--;
        end else begin
            mbuf[m_len] = b; mknown[m_len] = 1; m_len++;
            if (m_len == DEPTH) begin done = 1; m_trunc = 1; end
        end
`ifdef UART_LINE_ECHO_EN
        if (done) m_pend_hold = 1;
`else
        if (done) m_ready = 1;
`endif
    endtask

    // Model update, per-cycle comparison and UART/CPU responders, all on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
                continue;
            end
            if (p_rd_v && mknown[p_rd_idx]) check("rd_data", 32'(rd_data), 32'(mbuf[p_rd_idx]));
            if (p_line_ack) begin
                lines_done++;
                $display("line %0d released: len=%0d trunc=%0d", lines_done, m_len, m_trunc);
                m_ready = 0; m_len = 0; m_trunc = 0;
            end
            if (p_byte_v) apply_byte(p_byte);
            if (p_echo_ack && m_pend_hold) begin m_ready = 1; m_pend_hold = 0; end

            check("line_ready", 32'(line_ready), 32'(m_ready));
            check("line_len", 32'(line_len), 32'(m_len));
            if (m_ready) begin
                check("line_trunc", 32'(line_trunc), 32'(m_trunc));
                check("hold_no_poll", 32'(m_stb_o), 32'h0);
            end
            if (prev_rd_wait) check("stb_held", 32'({m_stb_o, m_we_o}), 32'h2);
            if (prev_rd_acc) check("stb_drop", 32'(m_stb_o), 32'h0);
            if (m_stb_o) check("adr_zero", m_adr_o, 32'h0);
`ifndef UART_LINE_ECHO_EN
            check("we_tied", 32'(m_we_o), 32'h0);
            check("dat_tied", m_dat_o, 32'h0);
`endif
            // UART read data lands one cycle after the accepted strobe
            p_byte_v = 0;
            if (data_next) begin
                m_dat_i = data_word;
                p_byte_v = data_word[8];
                p_byte = data_word[7:0];
                data_next = 0;
            end else begin
                m_dat_i = $urandom;
            end
            p_echo_ack = 0; prev_rd_wait = 0; prev_rd_acc = 0;
            if (m_stb_o && !m_we_o) begin
                if (rd_stall > 0) begin
                    m_ack_i = 1'b0; rd_stall--; prev_rd_wait = 1;
                end else begin
                    m_ack_i = 1'b1; prev_rd_acc = 1; data_next = 1;
                    data_word = $urandom;
                    if (rx_q.size() > 0) begin
                        data_word[8] = 1'b1;
                        data_word[7:0] = rx_q.pop_front();
                    end else begin
                        data_word[8] = 1'b0;
                    end
                    rd_stall = next_rd_stall();
                end
            end else if (m_stb_o && m_we_o) begin
                if (tx_stall > 0) begin
                    m_ack_i = 1'b0; tx_stall--;
                end else begin
                    m_ack_i = 1'b1; p_echo_ack = 1;
                    tx_log.push_back(m_dat_o[7:0]);
                    if (echo_exp.size() > 0) begin
                        check("echo_data", m_dat_o, {24'h0, echo_exp.pop_front()});
                    end else begin
                        checks++; errors++;
                        $display("FAIL echo_extra: got %0h, expected no write", m_dat_o);
                    end
                    tx_stall = next_tx_stall();
                end
            end else begin
                m_ack_i = 1'($urandom_range(0, 1));
            end
            // CPU side
            p_rd_idx = cpu_auto ? $urandom_range(0, DEPTH - 1) : dir_addr;
            rd_addr = 8'(p_rd_idx);
            p_rd_v = 1;
            if (cpu_auto) begin
                if (m_ready) begin
                    if (hold_cnt == 0) line_ack = 1'b1;
                    else begin line_ack = 1'b0; hold_cnt--; end
                end else begin
                    hold_cnt = $urandom_range(0, 6);
                    line_ack = ($urandom_range(0, 7) == 0);
                end
            end else begin
                line_ack = dir_ack;
                dir_ack = 0;
            end
            p_line_ack = line_ack && m_ready;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!line_ready && n < 3000) begin cyc(1); n++; end
        check({"wait_", nm}, 32'(line_ready), 32'h1);
    endtask

    task automatic read_check(input string nm, input int addr, input logic [7:0] exp);
        dir_addr = addr;
        cyc(2);
        check(nm, 32'(rd_data), 32'(exp));
    endtask

    task automatic release_line(input string nm);
        dir_ack = 1;
        cyc(2);
        check({"release_", nm}, 32'(line_ready), 32'h0);
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
    endtask

    function automatic logic [7:0] rand_byte();
        int r = $urandom_range(0, 15);
        if (r < 2) return 8'h0D;
        if (r == 2) return 8'h0A;
        if (r == 3) return 8'h08;
        if (r < 6) return 8'($urandom_range(0, 255));
        return 8'(8'h61 + $urandom_range(0, 25));
    endfunction

    initial begin
        int n;
        #12;
        check("rst_stb", 32'(m_stb_o), 32'h0);
        check("rst_we", 32'(m_we_o), 32'h0);
        check("rst_adr", m_adr_o, 32'h0);
        check("rst_dat", m_dat_o, 32'h0);
        check("rst_outs", 32'({line_ready, line_trunc, line_len}), 32'h0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        @(posedge clk); #2 rst = 1'b0;
        cyc(2);

        // hi<CR>
        push_str("hi\r");
        wait_ready("t1");
        check("t1_len", 32'(line_len), 32'd2);
        check("t1_trunc", 32'(line_trunc), 32'h0);
        read_check("t1_rd0", 0, 8'h68);
        read_check("t1_rd1", 1, 8'h69);
        release_line("t1");

        // ab<CR><LF> then c<CR>
        push_str("ab\r\n");
        wait_ready("t2a");
        check("t2a_len", 32'(line_len), 32'd2);
        release_line("t2a");
        push_str("c\r");
        wait_ready("t2b");
        check("t2b_len", 32'(line_len), 32'd1);
        read_check("t2b_rd0", 0, 8'h63);
        release_line("t2b");

        // truncation at DEPTH
        push_str("abcdef");
        wait_ready("t3a");
        check("t3a_len", 32'(line_len), 32'd4);
        check("t3a_trunc", 32'(line_trunc), 32'h1);
        read_check("t3a_rd3", 3, 8'h64);
        release_line("t3a");
        push_str("\r");
        wait_ready("t3b");
        check("t3b_len", 32'(line_len), 32'd2);
        check("t3b_trunc", 32'(line_trunc), 32'h0);
        read_check("t3b_rd0", 0, 8'h65);
        release_line("t3b");

        // backspace, including one at len 0
        rx_q.push_back(8'h61); rx_q.push_back(8'h08); rx_q.push_back(8'h08);
        rx_q.push_back(8'h62); rx_q.push_back(8'h0D);
        wait_ready("t4");
        check("t4_len", 32'(line_len), 32'd1);
        read_check("t4_rd0", 0, 8'h62);
        release_line("t4");

        // read ack held low for 20 cycles
        n = 0;
        while (m_stb_o && n < 200) begin cyc(1); n++; end
        rd_stall = 20;
        n = 0;
        while (!m_stb_o && n < 200) begin cyc(1); n++; end
        push_str("z\r");
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_stb_o && !m_we_o) n++;
            cyc(1);
        end
        check("t5_stb_cycles", 32'(n), 32'd20);
        wait_ready("t5");
        check("t5_len", 32'(line_len), 32'd1);
        read_check("t5_rd0", 0, 8'h7A);
        release_line("t5");

        // reset mid-RD_REQ with a partial line held
        stall_max = 0;
        push_str("qq");
        n = 0;
        while (line_len != 8'd2 && n < 500) begin cyc(1); n++; end
        check("t5_partial_len", 32'(line_len), 32'd2);
        n = 0;
        while (m_stb_o && n < 200) begin cyc(1); n++; end
        rd_stall = 1000;
        n = 0;
        while (!m_stb_o && n < 200) begin cyc(1); n++; end
        cyc(3);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_stb", 32'(m_stb_o), 32'h0);
        check("t5_rst_outs", 32'({m_we_o, line_ready, line_trunc, line_len}), 32'h0);
        check("t5_rst_dat", m_dat_o, 32'h0);
        check("t5_rst_rd_data", 32'(rd_data), 32'h0);
        cyc(3);
        @(posedge clk); #2 rst = 1'b0;
        n = 0;
        while (!m_stb_o && n < 100) begin cyc(1); n++; end
        check("t5_first_poll", 32'(n), 32'(P));
        n = 0;
        while (m_stb_o && n < 100) begin cyc(1); n++; end
        while (!m_stb_o && n < 100) begin cyc(1); n++; end
        check("poll_period", 32'(n), 32'(P + 2));

`ifdef UART_LINE_ECHO_EN
        // echo with TX back-pressure
        tx_log.delete();
        tx_force = 10;
        tx_stall = 10;
        push_str("x\r");
        wait_ready("t6");
        check("t6_echo_count", 32'(tx_log.size()), 32'd2);
        if (tx_log.size() == 2) begin
            check("t6_echo0", 32'(tx_log[0]), 32'h78);
            check("t6_echo1", 32'(tx_log[1]), 32'h0D);
        end
        check("t6_len", 32'(line_len), 32'd1);
        release_line("t6");
        tx_force = -1;
`endif

        // random phase
        stall_max = 3;
        cpu_auto = 1;
        for (int i = 0; i < 250; i++) begin
            cyc($urandom_range(0, 8));
            rx_q.push_back(rand_byte());
        end
        n = 0;
        while (rx_q.size() != 0 && n < 20000) begin cyc(1); n++; end
        check("drain_rx", 32'(rx_q.size()), 32'h0);
        cyc(100);
        cpu_auto = 0;
`ifdef UART_LINE_ECHO_EN
        check("echo_drained", 32'(echo_exp.size()), 32'h0);
`endif
        cyc(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
